// File: rtl/fp_normalize_pipe_pkg.sv
// Shared constants and result classification for the fp16 normalizer datapath.
`timescale 1ns/1ps
package fp16_pkg;

  localparam int MANT_W  = 11;
  localparam int EXP_W   = 5;
  localparam int EXP_MAX = 31;

  // Result class, encoded directly as the flag outputs {zero, uf, of}.
  typedef enum logic [2:0] {
    NORM   = 3'b000,
    ZERO   = 3'b100,
    DENORM = 3'b010,
    INF    = 3'b001
  } res_class_e;

endpackage

// File: rtl/fp_normalize_pipe_lshift.sv
// Combinational log-stage left shifter: 11-bit data, 4-bit amount, zero fill.
// Amounts of 11 and above shift everything out.
`timescale 1ns/1ps
module lshift_11bit (
  input  logic [10:0] data,
  input  logic [3:0]  amt,
  output logic [10:0] result
);

  logic [10:0] st0_s;
  logic [10:0] st1_s;
  logic [10:0] st2_s;

  assign st0_s  = amt[0] ? {data[9:0],  1'b0}  : data;
  assign st1_s  = amt[1] ? {st0_s[8:0], 2'b00} : st0_s;
  assign st2_s  = amt[2] ? {st1_s[6:0], 4'h0}  : st1_s;
  assign result = amt[3] ? {st2_s[2:0], 8'h00} : st2_s;

endmodule

// File: rtl/fp_normalize_pipe.sv
// Post-addition normalizer: two-stage valid/ready pipeline that renormalizes
// the raw significand sum and adjusts the biased exponent, flagging zero,
// denormal and overflow-to-infinity results.
`timescale 1ns/1ps
module fp_normalize_pipe
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   in_sum,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uf,
  output logic              out_of
);

  // Handshake / stall control
  logic              s1_adv_s;
  logic              s2_adv_s;

  // Stage 1 decode (combinational) and registers
  logic [3:0]        lz_s;
  logic [EXP_W-1:0]  e_s;
  logic              s1_valid_r;
  logic [MANT_W:0]   s1_sum_r;
  logic [EXP_W-1:0]  s1_e_r;
  logic              s1_carry_r;
  logic              s1_zero_r;
  logic [3:0]        s1_lz_r;

  // Stage 2 arithmetic (combinational) and registers
  logic [EXP_W:0]    e_ext_s;
  logic [EXP_W:0]    inc_s;
  logic [EXP_W:0]    em1_s;
  logic [EXP_W:0]    lz_ext_s;
  logic [EXP_W:0]    diff_s;
  logic              lz_fits_s;
  logic [3:0]        shamt_s;
  logic [MANT_W-1:0] shifted_s;
  logic [MANT_W-1:0] mant_s;
  logic [EXP_W-1:0]  exp_s;
  res_class_e        cls_s;
  logic              s2_valid_r;
  logic [MANT_W-1:0] s2_mant_r;
  logic [EXP_W-1:0]  s2_exp_r;
  res_class_e        s2_cls_r;

  assign s2_adv_s = !s2_valid_r || out_ready;
  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign in_ready = s1_adv_s;

  // An exponent of 0 behaves like 1 (denormal inputs share the minimum scale).
  assign e_s = (in_exp == 5'd0) ? 5'd1 : in_exp;

  // Leading-zero count of the sum below the carry bit; the highest set bit wins.
  always_comb begin
    lz_s = 4'd0;
    for (int i = 0; i < MANT_W; i++) begin
      if (in_sum[i]) begin
        lz_s = 4'(10 - i);
      end else begin
        lz_s = lz_s;
      end
    end
  end

  // Stage 1 register: captures E, the carry/zero decode and the lz count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sum_r   <= 12'd0;
      s1_e_r     <= 5'd0;
      s1_carry_r <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_lz_r    <= 4'd0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sum_r   <= in_sum;
        s1_e_r     <= e_s;
        s1_carry_r <= in_sum[MANT_W];
        s1_zero_r  <= (in_sum == 12'd0);
        s1_lz_r    <= lz_s;
      end
    end
  end

  // Exponent arithmetic is one bit wider so carry and underflow never wrap.
  assign e_ext_s   = {1'b0, s1_e_r};
  assign inc_s     = e_ext_s + 6'd1;
  assign em1_s     = e_ext_s - 6'd1;
  assign lz_ext_s  = {2'b00, s1_lz_r};
  assign diff_s    = e_ext_s - lz_ext_s;
  assign lz_fits_s = (lz_ext_s <= em1_s);

  // Shift amount: full lz when the exponent can absorb it, else clamp at E-1.
  always_comb begin
    shamt_s = 4'd0;
    if (lz_fits_s) begin
      shamt_s = s1_lz_r;
    end else begin
      shamt_s = em1_s[3:0];
    end
  end

  lshift_11bit u_lshift (
    .data   (s1_sum_r[MANT_W-1:0]),
    .amt    (shamt_s),
    .result (shifted_s)
  );

  // Result selection: carry renormalize, exact zero, normal shift or denormal.
  always_comb begin
    cls_s  = NORM;
    mant_s = 11'd0;
    exp_s  = 5'd0;
    if (s1_carry_r) begin
      if (inc_s >= 6'(EXP_MAX)) begin
        cls_s = INF;
        exp_s = 5'(EXP_MAX);
      end else begin
        mant_s = s1_sum_r[MANT_W:1];
        exp_s  = inc_s[EXP_W-1:0];
      end
    end else if (s1_zero_r) begin
      cls_s = ZERO;
    end else if (lz_fits_s) begin
      mant_s = shifted_s;
      exp_s  = diff_s[EXP_W-1:0];
    end else begin
      cls_s  = DENORM;
      mant_s = shifted_s;
    end
  end

  // Stage 2 register: holds the result until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_mant_r  <= 11'd0;
      s2_exp_r   <= 5'd0;
      s2_cls_r   <= NORM;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_mant_r <= mant_s;
        s2_exp_r  <= exp_s;
        s2_cls_r  <= cls_s;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_mant  = s2_mant_r;
  assign out_exp   = s2_exp_r;
  assign out_zero  = s2_cls_r[2];
  assign out_uf    = s2_cls_r[1];
  assign out_of    = s2_cls_r[0];

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Self-checking bench for fp_normalize_pipe: directed vectors, backpressure,
// mid-stream reset and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_fp_normalize_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_sum;
  logic [4:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_mant;
  logic [4:0]  out_exp;
  logic        out_zero;
  logic        out_uf;
  logic        out_of;

  int checks_r = 0;
  int errors_r = 0;
  int accepts_r = 0;
  int ivr_r = 0;   // 1: random gaps on in_valid
  int orm_r = 1;   // 0: out_ready low, 1: high, 2: random
  logic        held_v_r = 1'b0;
  logic [18:0] held_val_r;
  logic [18:0] exp_q[$];
  logic [16:0] pending_q[$];

  fp_normalize_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_uf    (out_uf),
    .out_of    (out_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_r++;
    if (got !== want) begin
      errors_r++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: {mant, exp, zero, uf, of} from the normalization rules.
  function automatic logic [18:0] ref_norm(input logic [11:0] s, input logic [4:0] e);
    int ee, p, lz, v;
    logic [10:0] m;
    ee = (e == 5'd0) ? 1 : int'(e);
    if (s[11]) begin
      if (ee + 1 >= 31) return {11'd0, 5'd31, 3'b001};
      return {s[11:1], 5'(ee + 1), 3'b000};
    end
    if (s == 12'd0) return {11'd0, 5'd0, 3'b100};
    p = 10;
    while (s[p] == 1'b0) p--;
    lz = 10 - p;
    v = int'(s[10:0]);
    if (lz <= ee - 1) begin
      v = v << lz;
      m = v[10:0];
      return {m, 5'(ee - lz), 3'b000};
    end
    v = v << (ee - 1);
    m = v[10:0];
    return {m, 5'd0, 3'b010};
  endfunction

  task automatic drive();
    if (pending_q.size() > 0 && (ivr_r == 0 || ($urandom % 3) != 0)) begin
      in_valid = 1'b1;
      {in_sum, in_exp} = pending_q[0];
    end else begin
      in_valid = 1'b0;
      in_sum   = 12'($urandom);
      in_exp   = 5'($urandom);
    end
    out_ready = (orm_r == 2) ? 1'($urandom % 2) : (orm_r == 1);
  endtask

  // One clock: evaluate transfers mid-cycle, then drive the next inputs.
  task automatic tick();
    logic [18:0] obs;
    logic [18:0] want;
    @(negedge clk);
    obs = {out_mant, out_exp, out_zero, out_uf, out_of};
    if (held_v_r) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", 32'(obs), 32'(held_val_r));
    end
    held_v_r = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 32'(out_valid), 32'd0);
        end else begin
          want = exp_q.pop_front();
          check_eq("result", 32'(obs), 32'(want));
        end
      end else begin
        held_v_r   = 1'b1;
        held_val_r = obs;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_norm(in_sum, in_exp));
      void'(pending_q.pop_front());
      accepts_r++;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pending_q.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(exp_q.size() + pending_q.size()), 32'd0);
  endtask

  // Single beat on an empty pipe with out_ready high; checks latency and result.
  task automatic send_dir(input string tag, input logic [11:0] s, input logic [4:0] e,
                          input logic [10:0] wm, input logic [4:0] we, input logic [2:0] wf);
    in_sum    = s;
    in_exp    = e;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_mant"}, 32'(out_mant), 32'(wm));
    check_eq({tag, "_exp"}, 32'(out_exp), 32'(we));
    check_eq({tag, "_flags"}, 32'({out_zero, out_uf, out_of}), 32'(wf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 12'd0;
    in_exp    = 5'd0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_outs", 32'({out_mant, out_exp, out_zero, out_uf, out_of}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    send_dir("norm",   12'h400, 5'd15, 11'h400, 5'd15, 3'b000);
    send_dir("carry",  12'hC00, 5'd15, 11'h600, 5'd16, 3'b000);
    send_dir("lz10",   12'h001, 5'd20, 11'h400, 5'd10, 3'b000);
    send_dir("uf",     12'h001, 5'd4,  11'h008, 5'd0,  3'b010);
    send_dir("of",     12'h800, 5'd30, 11'h000, 5'd31, 3'b001);
    send_dir("zero",   12'h000, 5'd7,  11'h000, 5'd0,  3'b100);
    send_dir("exp0",   12'h400, 5'd0,  11'h400, 5'd1,  3'b000);
    send_dir("uf_e1",  12'h200, 5'd1,  11'h200, 5'd0,  3'b010);
    send_dir("carry29",12'hFFF, 5'd29, 11'h7FF, 5'd30, 3'b000);
    send_dir("lzeq",   12'h020, 5'd6,  11'h400, 5'd1,  3'b000);

    // Backpressure: four beats with out_ready low for six cycles
    pending_q.push_back({12'h123, 5'd12});
    pending_q.push_back({12'hA5A, 5'd3});
    pending_q.push_back({12'h00F, 5'd9});
    pending_q.push_back({12'h000, 5'd21});
    accepts_r = 0;
    ivr_r = 0;
    orm_r = 0;
    drive();
    repeat (6) tick();
    check_eq("bp_accepts", 32'(accepts_r), 32'd2);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    orm_r = 1;
    drive();
    drain("bp_drain");
    check_eq("bp_total", 32'(accepts_r), 32'd4);

    // Reset mid-stream: fill the pipe, then reset and expect silence
    for (int i = 0; i < 4; i++) pending_q.push_back({12'($urandom), 5'($urandom)});
    orm_r = 0;
    drive();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mrst_outs", 32'({out_mant, out_exp, out_zero, out_uf, out_of}), 32'd0);
    pending_q.delete();
    exp_q.delete();
    held_v_r = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    orm_r = 1;
    drive();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random gaps and backpressure
    for (int i = 0; i < 400; i++) begin
      logic [11:0] s;
      case ($urandom % 4)
        0: s = 12'($urandom);
        1: s = 12'($urandom % 32);
        2: s = 12'h800 | 12'($urandom);
        default: s = 12'(11'($urandom) >> ($urandom % 11));
      endcase
      pending_q.push_back({s, 5'($urandom)});
    end
    ivr_r = 1;
    orm_r = 2;
    drive();
    repeat (600) tick();
    orm_r = 1;
    ivr_r = 0;
    drive();
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
